wb_regfile: RTL and testbench

- Writeback stage plus integer register file; consumes the MEM/WB pipeline register outputs (the reader side of that interface).
- Selects writeback data, commits it to a 32-entry register file and serves two combinational read ports to ID, with same-cycle write-through bypass.
- Keeps a pending-load scoreboard: ID marks a load destination busy at issue, and WB clears it on commit. Hazard logic uses the busy bits to stall.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_regfile_scoreboard.sv | 51 +++++
 rtl/wb_regfile.sv | 152 +++++++++++++++
 tb/tb_wb_regfile.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
// Shared constants for the writeback stage and integer register file.
//   XLEN        : integer data width
//   NREG        : architectural register count
//   REG_ADDR_W  : register address width (clog2(NREG))
//   WB_SRC_*    : writeback-source select encoding, shared with the decoder
//                 and the MEM/WB pipeline register
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_RAM = 1'b1;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// wb_scoreboard
// Pending-load busy bits, one per architectural register.
// ID marks a load destination busy at issue; WB clears it when the load
// commits. A set and a clear to the same register in one cycle leaves the
// bit set, since the set belongs to a newer, still outstanding load.
// Busy outputs read the registered vector only, so a clear becomes visible
// the cycle after the load commits.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   set_en, set_addr    : mark register busy (x0 ignored)
//   clr_en, clr_addr    : clear busy bit on load commit
//   rs1_addr, rs2_addr  : lookup addresses
//   busy_rs1, busy_rs2  : busy bit of each lookup address
module wb_scoreboard #(
  parameter int NREG = wb_regfile_pkg::NREG
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic       busy_rs1,
  output logic       busy_rs2
);
  import wb_regfile_pkg::*;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en)
      busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a same-address set wins.
    if (set_en && (set_addr != {REG_ADDR_W{1'b0}}))
      busy_d[set_addr] = 1'b1;
    if (!reset_n)
      busy_d = '0;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy_rs1 = busy_q[rs1_addr];
  assign busy_rs2 = busy_q[rs2_addr];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage plus integer register file, reader side of MEM/WB.
// Selects writeback data, commits it to the register array, serves two
// combinational read ports to ID (optional same-cycle write-through) and
// tracks pending loads in a busy-bit scoreboard for hazard stalls.
// Optional feature (macro WB_RETIRE_TRACE_EN): adds retire_count and
// last_retired_pc outputs.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   wb_valid                     : MEM/WB holds a real instruction
//   wb_ram_data, wb_alu_rd_result: writeback data candidates
//   wb_rd_address                : destination register
//   wb_reg_write_data_src        : 0 = ALU result, 1 = RAM data
//   wb_reg_wren                  : register write enable
//   wb_next_pc_data              : pc+4 of the WB instruction
//   rs1_addr/rs2_addr, rs1_data/rs2_data : ID read ports
//   sb_set_en, sb_set_addr       : ID issued a load to this register
//   busy_rs1, busy_rs2           : scoreboard bits of the read addresses
//   retire_count, last_retired_pc: retire trace (optional)
//   wb_data                      : selected writeback data
module wb_regfile #(
  parameter int XLEN   = wb_regfile_pkg::XLEN,
  parameter int NREG   = wb_regfile_pkg::NREG,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_ram_data,
  input  logic [XLEN-1:0] wb_alu_rd_result,
  input  logic [4:0]      wb_rd_address,
  input  logic            wb_reg_write_data_src,
  input  logic            wb_reg_wren,
  input  logic [XLEN-1:0] wb_next_pc_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            sb_set_en,
  input  logic [4:0]      sb_set_addr,
  output logic            busy_rs1,
  output logic            busy_rs2,
`ifdef WB_RETIRE_TRACE_EN
  output logic [63:0]     retire_count,
  output logic [XLEN-1:0] last_retired_pc,
`endif
  output logic [XLEN-1:0] wb_data
);
  import wb_regfile_pkg::*;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  logic            commit;
  logic            load_commit;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Writeback select and commit qualification
  assign wb_data     = (wb_reg_write_data_src == WB_SRC_RAM) ? wb_ram_data
                                                             : wb_alu_rd_result;
  assign commit      = wb_valid & wb_reg_wren & (wb_rd_address != X0);
  // Clear on any load writeback; clearing x0 is harmless as it is never set.
  assign load_commit = wb_valid & wb_reg_wren
                     & (wb_reg_write_data_src == WB_SRC_RAM);

  // Register array
  always_comb begin
    for (int i = 0; i < NREG; i++)
      regs_d[i] = regs_q[i];
    if (commit)
      regs_d[wb_rd_address] = wb_data;
    // x0 is held at zero so the array never carries a stale x0 value.
    regs_d[0] = '0;
    if (!reset_n)
      for (int i = 0; i < NREG; i++)
        regs_d[i] = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++)
      regs_q[i] <= regs_d[i];
  end

  // Read ports
  logic [1:0][REG_ADDR_W-1:0] rd_addr;
  logic [1:0][XLEN-1:0]       rd_data;

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd_data[p] = '0;
      if (rd_addr[p] != X0)
        rd_data[p] = regs_q[rd_addr[p]];
      // commit already excludes x0, so bypass never leaks into x0 reads.
      if ((BYPASS != 0) && commit && (rd_addr[p] == wb_rd_address))
        rd_data[p] = wb_data;
    end
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  // Pending-load scoreboard
  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .clr_en   (load_commit),
    .clr_addr (wb_rd_address),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );

`ifdef WB_RETIRE_TRACE_EN
  // Retire trace: every valid instruction retires, writing or not.
  logic [63:0]     retire_count_q, retire_count_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  always_comb begin
    retire_count_d = retire_count_q;
    last_pc_d      = last_pc_q;
    if (wb_valid) begin
      retire_count_d = retire_count_q + 64'd1;
      last_pc_d      = wb_next_pc_data - XLEN'(4);
    end
    if (!reset_n) begin
      retire_count_d = '0;
      last_pc_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    retire_count_q <= retire_count_d;
    last_pc_q      <= last_pc_d;
  end

  assign retire_count    = retire_count_q;
  assign last_retired_pc = last_pc_q;
`else
  // Next-pc only feeds the retire trace.
  logic unused_next_pc;
  assign unused_next_pc = ^wb_next_pc_data;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Self-checking bench for wb_regfile (default BYPASS=1). One table row per
// clock: inputs applied after the posedge, expected outputs queued, then
// popped and compared on the negedge. Hand-written sequences cover reset
// state, reset asserted mid-operation and (with WB_RETIRE_TRACE_EN) retire
// tracing.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid, wb_reg_write_data_src, wb_reg_wren;
  logic [31:0] wb_ram_data, wb_alu_rd_result, wb_next_pc_data;
  logic [4:0]  wb_rd_address, rs1_addr, rs2_addr, sb_set_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        sb_set_en, busy_rs1, busy_rs2;
`ifdef WB_RETIRE_TRACE_EN
  logic [63:0] retire_count;
  logic [31:0] last_retired_pc;
`endif

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .wb_valid              (wb_valid),
    .wb_ram_data           (wb_ram_data),
    .wb_alu_rd_result      (wb_alu_rd_result),
    .wb_rd_address         (wb_rd_address),
    .wb_reg_write_data_src (wb_reg_write_data_src),
    .wb_reg_wren           (wb_reg_wren),
    .wb_next_pc_data       (wb_next_pc_data),
    .rs1_addr              (rs1_addr),
    .rs2_addr              (rs2_addr),
    .rs1_data              (rs1_data),
    .rs2_data              (rs2_data),
    .sb_set_en             (sb_set_en),
    .sb_set_addr           (sb_set_addr),
    .busy_rs1              (busy_rs1),
    .busy_rs2              (busy_rs2),
`ifdef WB_RETIRE_TRACE_EN
    .retire_count          (retire_count),
    .last_retired_pc       (last_retired_pc),
`endif
    .wb_data               (wb_data)
  );

  typedef struct packed {
    logic        v, wren, src;
    logic [4:0]  rd;
    logic [31:0] alu, ram;
    logic [4:0]  rs1, rs2;
    logic        sb_en;
    logic [4:0]  sb_addr;
    logic [31:0] e_rs1, e_rs2, e_wbd;
    logic        e_b1, e_b2;
  } vec_t;

  typedef struct packed {
    logic [31:0] rs1, rs2, wbd;
    logic        b1, b2;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  vec_t vecs[20];

  function automatic vec_t mkv(logic v, logic wren, logic src, logic [4:0] rd,
                               logic [31:0] alu, logic [31:0] ram,
                               logic [4:0] rs1, logic [4:0] rs2,
                               logic sb_en, logic [4:0] sb_addr,
                               logic [31:0] e_rs1, logic [31:0] e_rs2,
                               logic [31:0] e_wbd, logic e_b1, logic e_b2);
    vec_t r;
    r = '{v, wren, src, rd, alu, ram, rs1, rs2, sb_en, sb_addr,
          e_rs1, e_rs2, e_wbd, e_b1, e_b2};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_reg_wren = 0; wb_reg_write_data_src = 0;
    wb_rd_address = 0; wb_alu_rd_result = 0; wb_ram_data = 0;
    wb_next_pc_data = 0; rs1_addr = 0; rs2_addr = 0;
    sb_set_en = 0; sb_set_addr = 0;
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    wb_valid = t.v; wb_reg_wren = t.wren; wb_reg_write_data_src = t.src;
    wb_rd_address = t.rd; wb_alu_rd_result = t.alu; wb_ram_data = t.ram;
    rs1_addr = t.rs1; rs2_addr = t.rs2;
    sb_set_en = t.sb_en; sb_set_addr = t.sb_addr;
    e = '{t.e_rs1, t.e_rs2, t.e_wbd, t.e_b1, t.e_b2};
    expq.push_back(e);
  endtask

  task automatic check_head(input int row);
    exp_t e;
    if (expq.size() == 0) begin
      chk($sformatf("row%0d queue_empty", row), 1, 0);
      return;
    end
    e = expq.pop_front();
    chk($sformatf("row%0d rs1_data", row), rs1_data, e.rs1);
    chk($sformatf("row%0d rs2_data", row), rs2_data, e.rs2);
    chk($sformatf("row%0d wb_data", row),  wb_data,  e.wbd);
    chk($sformatf("row%0d busy_rs1", row), busy_rs1, e.b1);
    chk($sformatf("row%0d busy_rs2", row), busy_rs2, e.b2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: v wren src rd alu ram | rs1 rs2 sb_en sb_addr | e_rs1 e_rs2 e_wbd e_b1 e_b2
    vecs[0]  = mkv(1,1,0,0,32'hDEADBEEF,0,         0,1, 0,0,  0,0,32'hDEADBEEF,0,0);
    vecs[1]  = mkv(0,0,0,0,0,0,                    0,0, 0,0,  0,0,0,0,0);
    vecs[2]  = mkv(1,1,0,5,32'h12345678,0,         5,5, 0,0,  32'h12345678,32'h12345678,32'h12345678,0,0);
    vecs[3]  = mkv(0,0,0,0,0,0,                    5,0, 0,0,  32'h12345678,0,0,0,0);
    vecs[4]  = mkv(1,1,1,7,32'h1,32'hCAFEF00D,     7,5, 0,0,  32'hCAFEF00D,32'h12345678,32'hCAFEF00D,0,0);
    vecs[5]  = mkv(0,1,1,7,0,32'h11111111,         7,7, 0,0,  32'hCAFEF00D,32'hCAFEF00D,32'h11111111,0,0);
    vecs[6]  = mkv(0,0,0,0,0,0,                    7,0, 0,0,  32'hCAFEF00D,0,0,0,0);
    vecs[7]  = mkv(0,0,0,0,0,0,                    0,9, 1,9,  0,0,0,0,0);
    vecs[8]  = mkv(0,0,0,0,0,0,                    0,9, 0,0,  0,0,0,0,1);
    vecs[9]  = mkv(1,1,1,9,0,32'hABCD0009,         0,9, 0,0,  0,32'hABCD0009,32'hABCD0009,0,1);
    vecs[10] = mkv(0,0,0,0,0,0,                    0,9, 0,0,  0,32'hABCD0009,0,0,0);
    vecs[11] = mkv(0,0,0,0,0,0,                    0,9, 1,9,  0,32'hABCD0009,0,0,0);
    vecs[12] = mkv(1,1,1,9,0,32'h99,               0,9, 1,9,  0,32'h99,32'h99,0,1);
    vecs[13] = mkv(0,0,0,0,0,0,                    0,9, 0,0,  0,32'h99,0,0,1);
    vecs[14] = mkv(0,0,0,0,0,0,                    0,0, 1,0,  0,0,0,0,0);
    vecs[15] = mkv(0,0,0,0,0,0,                    0,0, 0,0,  0,0,0,0,0);
    vecs[16] = mkv(1,1,1,9,0,32'h1234,             9,10,1,10, 32'h1234,0,32'h1234,1,0);
    vecs[17] = mkv(0,0,0,0,0,0,                    9,10,0,0,  32'h1234,0,0,0,1);
    vecs[18] = mkv(1,1,0,10,32'h55,0,              0,10,0,0,  0,32'h55,32'h55,0,1);
    vecs[19] = mkv(0,0,0,0,0,0,                    0,10,0,0,  0,32'h55,0,0,1);

    idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset state: every register and busy bit reads zero.
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      chk($sformatf("reset x%0d rs1", a), rs1_data, 0);
      chk($sformatf("reset x%0d rs2", a), rs2_data, 0);
      chk($sformatf("reset x%0d busy", a), {busy_rs1, busy_rs2}, 0);
    end
    // wb_data follows its inputs regardless of wb_valid.
    wb_alu_rd_result = 32'hA5A5; wb_ram_data = 32'h5A5A; wb_reg_write_data_src = 0;
    #1 chk("wbsel alu", wb_data, 32'hA5A5);
    wb_reg_write_data_src = 1;
    #1 chk("wbsel ram", wb_data, 32'h5A5A);
    idle();

    // Table-driven main sequence.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check_head(i);
    end

    // Reset mid-operation: x3=5, bits 3 and 4 busy, then reset with a
    // pending commit to x3 and a pending set of x5.
    @(posedge clk); #1;
    idle();
    wb_valid = 1; wb_reg_wren = 1; wb_rd_address = 3; wb_alu_rd_result = 5;
    sb_set_en = 1; sb_set_addr = 3;
    @(posedge clk); #1;
    idle();
    sb_set_en = 1; sb_set_addr = 4;
    @(posedge clk); #1;
    idle();
    rs1_addr = 3; rs2_addr = 4;
    @(negedge clk);
    chk("pre_reset x3", rs1_data, 5);
    chk("pre_reset busy3", busy_rs1, 1);
    chk("pre_reset busy4", busy_rs2, 1);
    @(posedge clk); #1;
    reset_n = 0;
    wb_valid = 1; wb_reg_wren = 1; wb_rd_address = 3; wb_alu_rd_result = 32'h77;
    wb_next_pc_data = 32'h400;
    sb_set_en = 1; sb_set_addr = 5;
    @(posedge clk); #1;
    reset_n = 1;
    idle();
    rs1_addr = 3; rs2_addr = 4;
    @(negedge clk);
    chk("post_reset x3", rs1_data, 0);
    chk("post_reset busy3", busy_rs1, 0);
    chk("post_reset busy4", busy_rs2, 0);
    rs2_addr = 5;
    #1 chk("post_reset busy5", busy_rs2, 0);

`ifdef WB_RETIRE_TRACE_EN
    chk("retire after reset", retire_count, 0);
    chk("last_pc after reset", last_retired_pc, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      idle();
      wb_valid        = (k != 3);
      wb_next_pc_data = (k == 3) ? 32'h200 : 32'h104 + 32'(k) * 4;
      if (k == 4) wb_next_pc_data = 32'h110;
    end
    @(posedge clk); #1;
    idle();
    chk("retire_count", retire_count, 4);
    chk("last_retired_pc", last_retired_pc, 32'h10C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
